lit_bcd_display: RTL and testbench

//  Sequential binary-to-decimal display driver for the pump litre/price readouts.
//  - Captures a binary count on a start strobe.
//  - Converts it with an iterative double-dabble engine, one shift per clock.
//  - Drives DIGITS seven-segment digits from a registered result, with

---
 rtl/lit_disp_pkg.sv | 34 +++
 rtl/lit_bcd_display_if.sv | 23 ++
 rtl/lit_bcd_display_dec.sv | 27 ++
 rtl/lit_bcd_display.sv | 174 +++++++++++++++++
 tb/tb_lit_bcd_display.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/lit_disp_pkg.sv
// Shared types and constants for the litre/price BCD display driver.
package lit_disp_pkg;

    // Conversion sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, 1 = segment lit
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // BCD digits needed for a bin_w-bit value: floor(bin_w*0.301)+1.
    // Repeated subtraction keeps the block free of divide operators.
    function automatic int nb_width(input int bin_w);
        int scaled;
        int q;
        scaled = bin_w * 301;
        q      = 0;
        while (scaled >= 1000) begin
            scaled = scaled - 1000;
            q      = q + 1;
        end
        return q + 1;
    endfunction

    // Double-dabble correction step for one nibble
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/lit_bcd_display_if.sv
// Request/result bundle between the pump controller and the display driver.
interface lit_bcd_display_if #(
    parameter int unsigned BIN_W  = 24,
    parameter int unsigned DIGITS = 7
);
    logic [BIN_W-1:0]    lit;
    logic                start;
    logic                blank_lz;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [7*DIGITS-1:0] seg;

    modport master (
        output lit, start, blank_lz,
        input  busy, done, overflow, seg
    );

    modport slave (
        input  lit, start, blank_lz,
        output busy, done, overflow, seg
    );
endinterface

// File: rtl/lit_bcd_display_dec.sv
// Seven-segment decoder for one BCD digit; non-decimal codes show nothing.
module lit_bcd_display_dec
    import lit_disp_pkg::*;
(
    input  logic [3:0] cnt,
    output logic [6:0] led
);

    // Digit to segment pattern, {g,f,e,d,c,b,a}
    always_comb begin
        led = SEG_BLANK;
        case (cnt)
            4'd0:    led = 7'h3F;
            4'd1:    led = 7'h06;
            4'd2:    led = 7'h5B;
            4'd3:    led = 7'h4F;
            4'd4:    led = 7'h66;
            4'd5:    led = 7'h6D;
            4'd6:    led = 7'h7D;
            4'd7:    led = 7'h07;
            4'd8:    led = 7'h7F;
            4'd9:    led = 7'h6F;
            default: led = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/lit_bcd_display.sv
// Sequential binary-to-BCD display driver: captures a count, converts it with
// one double-dabble shift per clock and drives DIGITS seven-segment digits
// from a registered result.
module lit_bcd_display
    import lit_disp_pkg::*;
#(
    parameter int unsigned BIN_W  = 24,
    parameter int unsigned DIGITS = 7
) (
    input  logic             clk,
    input  logic             rst,
    lit_bcd_display_if.slave bus
);

    localparam int unsigned NB    = nb_width(BIN_W);
    localparam int unsigned PAD   = (NB > DIGITS) ? NB : DIGITS;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [4*NB-1:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               blank_cap_q, blank_cap_d;
    logic [4*NB-1:0]    result_q, result_d;
    logic               blank_res_q, blank_res_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;

    logic [4*NB-1:0]       bcd_adj;
    logic [4*NB+BIN_W-1:0] joined;
    logic [4*NB-1:0]       bcd_next;
    logic [BIN_W-1:0]      bin_next;
    logic                  hi_nonzero;
    logic [4*PAD-1:0]      res_pad;
    logic [6:0]            led [DIGITS];
    logic [DIGITS-1:0]     lead_zero;
    logic [7*DIGITS-1:0]   seg_v;

    // Add-3 correction on every nibble, then shift {bcd,bin} left by one
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < int'(NB); i++) begin
            bcd_adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
        end
        joined   = {bcd_adj, bin_q} << 1;
        bcd_next = joined[4*NB+BIN_W-1:BIN_W];
        bin_next = joined[BIN_W-1:0];
    end

    // Nibbles beyond the display width mean the value does not fit
    generate
        if (NB > DIGITS) begin : g_ovf
            assign hi_nonzero = |bcd_q[4*NB-1:4*DIGITS];
        end else begin : g_no_ovf
            assign hi_nonzero = 1'b0;
        end
    endgenerate

    // Next-state and datapath update for the IDLE -> SHIFT -> LATCH sequence
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        blank_cap_d = blank_cap_q;
        result_d    = result_q;
        blank_res_d = blank_res_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_SHIFT;
                    bin_d       = bus.lit;
                    bcd_d       = '0;
                    cnt_d       = '0;
                    blank_cap_d = bus.blank_lz;
                end
            end
            S_SHIFT: begin
                bin_d = bin_next;
                bcd_d = bcd_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                result_d    = bcd_q;
                blank_res_d = blank_cap_q;
                overflow_d  = hi_nonzero;
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset leaves a blank-leading "0" on the display
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            blank_cap_q <= 1'b0;
            result_q    <= '0;
            blank_res_q <= 1'b1;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            blank_cap_q <= blank_cap_d;
            result_q    <= result_d;
            blank_res_q <= blank_res_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

    // Zero-extend the result so every displayed digit has a nibble
    generate
        if (PAD > NB) begin : g_pad
            assign res_pad = {{(4*(PAD-NB)){1'b0}}, result_q};
        end else begin : g_nopad
            assign res_pad = result_q;
        end
    endgenerate

    genvar k;
    generate
        for (k = 0; k < int'(DIGITS); k++) begin : g_dig
            lit_bcd_display_dec u_dec (
                .cnt (res_pad[4*k +: 4]),
                .led (led[k])
            );
        end
    endgenerate

    // Flag digits that sit above the most significant nonzero digit
    always_comb begin
        logic zero_above;
        lead_zero  = '0;
        zero_above = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            lead_zero[i] = zero_above && (res_pad[4*i +: 4] == 4'd0);
            zero_above   = lead_zero[i];
        end
    end

    // Per-digit select: dash on overflow, blank for leading zeros, else digit
    always_comb begin
        seg_v = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (overflow_q) begin
                seg_v[7*i +: 7] = SEG_DASH;
            end else if (blank_res_q && lead_zero[i] && (i != 0)) begin
                seg_v[7*i +: 7] = SEG_BLANK;
            end else begin
                seg_v[7*i +: 7] = led[i];
            end
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.seg      = seg_v;

endmodule

// File: tb/tb_lit_bcd_display.sv
// Directed bench for lit_bcd_display: one 7-digit and one 8-digit instance
// driven with the same stimulus.
module tb_lit_bcd_display;

    localparam int B = 10;  // blank digit
    localparam int D = 11;  // dash digit
    localparam logic [63:0] MASK7 = (64'd1 << 49) - 64'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] lit = '0;
    logic        start = 1'b0;
    logic        blank = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    lit_bcd_display_if #(.BIN_W(24), .DIGITS(7)) bus7 ();
    lit_bcd_display_if #(.BIN_W(24), .DIGITS(8)) bus8 ();

    assign bus7.lit      = lit;
    assign bus7.start    = start;
    assign bus7.blank_lz = blank;
    assign bus8.lit      = lit;
    assign bus8.start    = start;
    assign bus8.blank_lz = blank;

    lit_bcd_display #(.BIN_W(24), .DIGITS(7)) dut7 (
        .clk (clk),
        .rst (rst),
        .bus (bus7)
    );

    lit_bcd_display #(.BIN_W(24), .DIGITS(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] sd(input int d);
        case (d)
            0:       return 7'h3F;
            1:       return 7'h06;
            2:       return 7'h5B;
            3:       return 7'h4F;
            4:       return 7'h66;
            5:       return 7'h6D;
            6:       return 7'h7D;
            7:       return 7'h07;
            8:       return 7'h7F;
            9:       return 7'h6F;
            D:       return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    // Digits listed most significant (digit 7) first
    function automatic logic [63:0] mk(input int d7, input int d6, input int d5, input int d4,
                                       input int d3, input int d2, input int d1, input int d0);
        int d [8];
        logic [63:0] r;
        d = '{d0, d1, d2, d3, d4, d5, d6, d7};
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[7*i +: 7] = sd(d[i]);
        end
        return r;
    endfunction

    // Start one conversion, scramble lit mid-way, measure latency and busy time
    task automatic convert(input logic [23:0] v, input logic blz, output int cyc,
                           output int nbusy);
        @(negedge clk);
        lit   = v;
        blank = blz;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        nbusy = 0;
        while (cyc < 200) begin
            if (bus7.done) break;
            if (bus7.busy) nbusy++;
            if (cyc == 3) lit = ~v;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int nbusy;
        int ndone;
        logic [63:0] e;

        // Reset state
        #12;
        check("rst_busy", 64'(bus7.busy), 64'd0);
        check("rst_done", 64'(bus7.done), 64'd0);
        check("rst_ovf", 64'(bus7.overflow), 64'd0);
        e = mk(B, B, B, B, B, B, B, 0);
        check("rst_seg7", 64'(bus7.seg), e & MASK7);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_seg7", 64'(bus7.seg), e & MASK7);
        check("idle_busy", 64'(bus7.busy), 64'd0);

        // 1234567 without blanking
        convert(24'd1234567, 1'b0, cyc, nbusy);
        check("lat_1234567", 64'(cyc), 64'd26);
        check("busy_cycles", 64'(nbusy), 64'd25);
        check("busy_at_done", 64'(bus7.busy), 64'd0);
        check("ovf_1234567", 64'(bus7.overflow), 64'd0);
        e = mk(0, 1, 2, 3, 4, 5, 6, 7);
        check("seg7_1234567", 64'(bus7.seg), e & MASK7);
        check("seg8_1234567", 64'(bus8.seg), e);
        @(posedge clk);
        #1;
        check("done_pulse", 64'(bus7.done), 64'd0);
        check("seg7_hold", 64'(bus7.seg), e & MASK7);

        // Leading-zero blanking
        convert(24'd305, 1'b1, cyc, nbusy);
        e = mk(B, B, B, B, B, 3, 0, 5);
        check("seg7_305", 64'(bus7.seg), e & MASK7);
        convert(24'd0, 1'b1, cyc, nbusy);
        e = mk(B, B, B, B, B, B, B, 0);
        check("seg7_0", 64'(bus7.seg), e & MASK7);

        // Full-scale value: overflows 7 digits, fits 8
        convert(24'd16777215, 1'b1, cyc, nbusy);
        check("ovf7_max", 64'(bus7.overflow), 64'd1);
        e = mk(D, D, D, D, D, D, D, D);
        check("seg7_max", 64'(bus7.seg), e & MASK7);
        check("ovf8_max", 64'(bus8.overflow), 64'd0);
        e = mk(1, 6, 7, 7, 7, 2, 1, 5);
        check("seg8_max", 64'(bus8.seg), e);

        // Reset in the middle of a conversion of 999
        @(negedge clk);
        lit   = 24'd999;
        blank = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("busy_mid", 64'(bus7.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(bus7.busy), 64'd0);
        check("abort_done", 64'(bus7.done), 64'd0);
        check("abort_ovf", 64'(bus7.overflow), 64'd0);
        e = mk(B, B, B, B, B, B, B, 0);
        check("abort_seg7", 64'(bus7.seg), e & MASK7);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus7.done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        convert(24'd999, 1'b1, cyc, nbusy);
        check("lat_999", 64'(cyc), 64'd26);
        e = mk(B, B, B, B, B, 9, 9, 9);
        check("seg7_999", 64'(bus7.seg), e & MASK7);

        // Start held for 40 cycles; lit changes at cycle 10
        @(negedge clk);
        lit   = 24'd42;
        blank = 1'b0;
        start = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (c == 10) lit = 24'd99;
            if (c == 40) start = 1'b0;
            if (bus7.done) begin
                ndone++;
                if (ndone == 1) begin
                    check("held_done1_cyc", 64'(c), 64'd26);
                    e = mk(0, 0, 0, 0, 0, 0, 4, 2);
                    check("held_seg7_42", 64'(bus7.seg), e & MASK7);
                end else begin
                    check("held_done2_cyc", 64'(c), 64'd52);
                    e = mk(0, 0, 0, 0, 0, 0, 9, 9);
                    check("held_seg7_99", 64'(bus7.seg), e & MASK7);
                end
            end
        end
        check("held_ndone", 64'(ndone), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
